// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  localparam int I2S_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronizes the asynchronous I2S pins into i_clk and detects serial-clock rising edges.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tclk,
  input  logic i_ws,
  input  logic i_td,
  output logic o_rise,
  output logic o_ws,
  output logic o_td
);

  logic [SYNC_STAGES-1:0] r_tclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_td_sync;
  logic                   r_tclk_prev;

  // Equal-depth chains keep ws/td aligned with the detected tclk edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tclk_sync <= '0;
      r_ws_sync   <= '0;
      r_td_sync   <= '0;
      r_tclk_prev <= 1'b0;
    end else begin
      r_tclk_sync <= {r_tclk_sync[SYNC_STAGES-2:0], i_tclk};
      r_ws_sync   <= {r_ws_sync[SYNC_STAGES-2:0], i_ws};
      r_td_sync   <= {r_td_sync[SYNC_STAGES-2:0], i_td};
      r_tclk_prev <= r_tclk_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_tclk_sync[SYNC_STAGES-1] & ~r_tclk_prev;
  assign o_ws   = r_ws_sync[SYNC_STAGES-1];
  assign o_td   = r_td_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) receiver: deserializes left/right words and presents stereo pairs
// on a valid/ready interface, flagging pairs dropped while the consumer stalls.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_tclk,
  input  logic              i_ws,
  input  logic              i_td,
  output logic [DATA_W-1:0] o_data_left,
  output logic [DATA_W-1:0] o_data_right,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun,
  output logic              o_active
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              w_rise;
  logic              w_ws;
  logic              w_td;
  logic              w_ws_edge;
  logic              w_can_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_word;
  logic              w_pair;

  rx_state_t         r_state;
  logic              r_ws_prev;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_left_hold;
  logic              r_left_vld;

  // Short words are left-justified; n is always >= 1 when a word completes.
  function automatic logic [DATA_W-1:0] justify(input logic [DATA_W-1:0] w,
                                                input logic [CNT_W-1:0]  n);
    return w << (DATA_W - int'(n));
  endfunction

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tclk (i_tclk),
    .i_ws   (i_ws),
    .i_td   (i_td),
    .o_rise (w_rise),
    .o_ws   (w_ws),
    .o_td   (w_td)
  );

  // The bit sampled on a ws-change rise is the LSB of the finishing word, so fold it in.
  assign w_ws_edge    = w_rise & (w_ws != r_ws_prev);
  assign w_can_shift  = r_bit_cnt < CNT_W'(DATA_W);
  assign w_shift_next = w_can_shift ? {r_shift[DATA_W-2:0], w_td} : r_shift;
  assign w_cnt_next   = w_can_shift ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;
  assign w_word       = justify(w_shift_next, w_cnt_next);
  assign w_pair       = i_enable && (r_state == ST_CAPTURE) && w_ws_edge &&
                        r_ws_prev && r_left_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_ws_prev    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_left_hold  <= '0;
      r_left_vld   <= 1'b0;
      o_data_left  <= '0;
      o_data_right <= '0;
      o_valid      <= 1'b0;
      o_overrun    <= 1'b0;
      o_active     <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (w_rise) r_ws_prev <= w_ws;

      if (w_pair) begin
        if (o_valid && !i_ready) begin
          o_overrun <= 1'b1;
        end else begin
          o_data_left  <= r_left_hold;
          o_data_right <= w_word;
          o_valid      <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (!i_enable) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_left_vld <= 1'b0;
        o_valid    <= 1'b0;
        o_active   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_left_vld <= 1'b0;
            o_valid    <= 1'b0;
            o_active   <= 1'b0;
            r_state    <= ST_ALIGN;
          end
          ST_ALIGN: begin
            // A ws 1->0 change means the next rise carries a left MSB.
            if (w_ws_edge && r_ws_prev) begin
              r_bit_cnt <= '0;
              r_shift   <= '0;
              o_active  <= 1'b1;
              r_state   <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (w_ws_edge) begin
              r_bit_cnt <= '0;
              r_shift   <= '0;
              if (!r_ws_prev) begin
                r_left_hold <= w_word;
                r_left_vld  <= 1'b1;
              end else begin
                r_left_vld  <= 1'b0;
              end
            end else if (w_rise) begin
              r_bit_cnt <= w_cnt_next;
              r_shift   <= w_shift_next;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            o_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver core: the receive-side counterpart of the i2s_tx serializer.
- Samples externally driven serial clock, word select and serial data, then deserializes left and right words MSB-first.
- Presents each completed stereo pair on a valid/ready interface for a receive FIFO or an APB wrapper.
- Runs entirely in the system clock domain; the I2S inputs are asynchronous and synchronized internally.

Parameters:
- DATA_W, 32: bits per channel word delivered.
- SYNC_STAGES, 2: synchronizer flops on i_tclk/i_ws/i_td (minimum 2).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  receiver enable
- i_tclk  in  1  I2S serial clock (async)
- i_ws  in  1  I2S word select (async), 0 = left, 1 = right
- i_td  in  1  I2S serial data (async)
- o_data_left  out  DATA_W  received left word
- o_data_right  out  DATA_W  received right word
- o_valid  out  1  stereo pair available
- i_ready  in  1  consumer accepts pair
- o_overrun  out  1  one-cycle pulse: a completed pair was dropped
- o_active  out  1  receiver frame-aligned and capturing

Behaviour:
- Reset values: o_data_left/right = 0, o_valid = 0, o_overrun = 0, o_active = 0, FSM = IDLE, counters and shift register = 0.
- Synchronization:
  - i_tclk, i_ws and i_td pass through equal-depth SYNC_STAGES chains, so they stay mutually aligned.
  - One extra tclk flop provides rising-edge detect (rise = sync & ~prev).
  - Every action below occurs only on an i_clk cycle where rise = 1.
  - Constraint: i_tclk high and low phases are each at least 2 i_clk periods.
- Protocol (Philips I2S):
  - WS changes one SCK before the new word's MSB.
  - At each rise, compare ws with ws_prev (the value latched at the previous rise).
  - If they differ, the bit sampled on this rise is the LSB of the channel ws_prev, and that word completes.
- FSM states:
  - IDLE: entered from reset or whenever i_enable = 0. Clears the shift register, counter and o_valid; o_active = 0. Goes to ALIGN when i_enable = 1.
  - ALIGN: discards bits and waits for a rise with a ws 1->0 transition (first left MSB follows). Then clears the counter and goes to CAPTURE; o_active = 1.
  - CAPTURE, on each rise:
    - Shift i_td in if bit_cnt < DATA_W; bit_cnt saturates at DATA_W.
    - On a ws transition, finalize the word:
      - Shorter than DATA_W: left-justify (zero-fill LSBs).
      - Longer than DATA_W: keep the first DATA_W bits received; extra bits are ignored.
    - Then reset bit_cnt to 0.
- Pair assembly:
  - A completed left word goes to a holding register.
  - A completed right word, when a left word is held from the same frame, forms a pair.
  - A right word without a preceding left word (first frame only) is discarded.
- Output handshake:
  - A new pair loads o_data_left/right and sets o_valid in the i_clk cycle after the completing rise.
  - o_valid and data stay stable until a cycle with o_valid & i_ready, which clears o_valid.
  - Acceptance and a new pair load in the same cycle: the load wins and o_valid stays 1.
- Overrun: a pair completing while o_valid = 1 and i_ready = 0 is dropped. Output data is unchanged and o_overrun pulses for 1 cycle.
- i_enable drop mid-word: go to IDLE on the next cycle, clear o_valid, and discard the partial word. Re-enable requires realignment in ALIGN.
- Asynchronous reset mid-frame: all state clears immediately; no partial output appears.

Decomposition:
- Shared package i2s_pkg: rx_state_t enum (IDLE, ALIGN, CAPTURE) and the I2S_WORD_W = 32 default constant.
- Sub-module i2s_rx_sync: SYNC_STAGES synchronizers plus tclk rising-edge detect. Outputs rise, ws_s and td_s, all aligned.

Test Plan:
1. Enable, send frame L = 0xA5A5_0001, R = 0x1234_5678 (32-bit, after alignment), i_ready = 1 -> one o_valid pulse with exactly those values; o_active = 1.
2. Send 3 frames with i_ready = 0 -> first pair held with o_valid = 1, o_overrun pulses twice, data stays the first pair; raise i_ready -> o_valid drops next cycle.
3. 16-bit words L = 0xBEEF, R = 0xCAFE -> o_data_left = 0xBEEF_0000, o_data_right = 0xCAFE_0000.
4. 40-bit slots -> only the first 32 MSBs delivered per channel; no overrun.
5. Enable in the middle of a right word -> no output until after a full ws 1->0 alignment; first output is the next complete L/R pair.
6. Deassert i_enable mid-left-word with o_valid = 1 -> o_valid = 0 and o_active = 0 next cycle; assert i_rst_n = 0 mid-frame -> all outputs 0 immediately.
